video_decimator_nppc: RTL and testbench



---
 rtl/video_decimator_nppc_if.sv | 27 ++
 rtl/video_decimator_nppc.sv | 164 ++++++++++++++++
 tb/tb_video_decimator_nppc.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_decimator_nppc_if.sv
// AXI4-Stream video beat bundle shared by the decimator's slave and master sides.
// Carries tdata plus end-of-line (tlast) and start-of-frame (tuser) markers.
interface video_decimator_nppc_if #(
    parameter int DATA_W = 96
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tuser;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/video_decimator_nppc.sv
// Multi-pixel-per-clock video decimator: keeps every Fc-th column and Fl-th line,
// packing surviving pixels into full-width output beats with per-frame config.
module video_decimator_nppc #(
    parameter int SAMPLES_PER_CLOCK = 4,
    parameter int PIXEL_WIDTH       = 24,
    parameter int LINE_FACTOR_BITS  = 4,
    parameter int COL_LOG2_BITS     = 2,
    parameter int AXIS_WIDTH        = SAMPLES_PER_CLOCK * PIXEL_WIDTH
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [COL_LOG2_BITS-1:0]    cfg_col_log2,
    input  logic [LINE_FACTOR_BITS-1:0] cfg_line_factor,
    video_decimator_nppc_if.slave       s_axis,
    video_decimator_nppc_if.master      m_axis,
    output logic                        frame_done
);
    localparam int SPC  = SAMPLES_PER_CLOCK;
    localparam int PW   = PIXEL_WIDTH;
    localparam int LFB  = LINE_FACTOR_BITS;
    localparam int LOG2 = $clog2(SPC);
    localparam int IW   = (LOG2 > 0) ? LOG2 : 1;
    localparam int FW   = (LOG2 > 0) ? $clog2(LOG2 + 1) : 1;

    logic [FW-1:0]         fc_q;
    logic [LFB-1:0]        fl_q;
    logic [LFB-1:0]        line_cnt;
    logic [IW-1:0]         pack_cnt;
    logic [AXIS_WIDTH-1:0] pack_buf;
    logic                  sof_pend;
    logic                  fd_pend;

    logic                  acc_in;
    logic                  acc_out;
    logic                  sof;
    logic [FW-1:0]         fc_cfg;
    logic [LFB-1:0]        fl_cfg;
    logic [FW-1:0]         fc_eff;
    logic [LFB-1:0]        fl_eff;
    logic [LFB-1:0]        cur_line;
    logic [IW-1:0]         cur_pack;
    logic [AXIS_WIDTH-1:0] base_buf;
    logic [AXIS_WIDTH-1:0] pack_nxt;
    logic [LFB-1:0]        line_nxt;
    logic [IW-1:0]         pack_cnt_nxt;
    logic                  keep;
    logic                  full;
    logic                  emit;
    logic [PW-1:0]         pix_in [SPC];

    assign s_axis.tready = aresetn & (~m_axis.tvalid | m_axis.tready);
    assign acc_in        = s_axis.tvalid & s_axis.tready;
    assign acc_out       = m_axis.tvalid & m_axis.tready;
    assign sof           = s_axis.tuser;

    always_comb begin
        for (int i = 0; i < SPC; i++) begin
            pix_in[i] = s_axis.tdata[i*PW +: PW];
        end
    end

    // Column factor saturates at one kept pixel per beat; line factor 0 acts as 1.
    always_comb begin
        fc_cfg = FW'(cfg_col_log2);
        if (int'(cfg_col_log2) > LOG2) begin
            fc_cfg = FW'(LOG2);
        end
        fl_cfg = cfg_line_factor;
        if (cfg_line_factor == '0) begin
            fl_cfg = LFB'(1);
        end
    end

    // An SOF beat belongs to the new frame, so it already sees fresh config/counters.
    always_comb begin
        fc_eff   = sof ? fc_cfg : fc_q;
        fl_eff   = sof ? fl_cfg : fl_q;
        cur_line = sof ? '0 : line_cnt;
        cur_pack = sof ? '0 : pack_cnt;
        base_buf = sof ? '0 : pack_buf;
    end

    always_comb begin
        int n_i;
        int base_i;
        keep     = (cur_line == '0);
        n_i      = SPC >> fc_eff;
        base_i   = int'(cur_pack) * n_i;
        full     = (int'(cur_pack) == ((1 << fc_eff) - 1));
        emit     = keep & (full | s_axis.tlast);
        pack_nxt = base_buf;
        for (int j = 0; j < SPC; j++) begin
            int rel;
            int idx;
            rel = j - base_i;
            idx = rel << fc_eff;
            if (keep && rel >= 0 && rel < n_i) begin
                pack_nxt[j*PW +: PW] = pix_in[IW'(idx)];
            end
        end
    end

    always_comb begin
        line_nxt = cur_line;
        if (s_axis.tlast) begin
            if (cur_line >= fl_eff - LFB'(1)) begin
                line_nxt = '0;
            end else begin
                line_nxt = cur_line + LFB'(1);
            end
        end
        pack_cnt_nxt = cur_pack + IW'(1);
        if (!keep || s_axis.tlast || full) begin
            pack_cnt_nxt = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            fc_q          <= '0;
            fl_q          <= LFB'(1);
            line_cnt      <= '0;
            pack_cnt      <= '0;
            pack_buf      <= '0;
            sof_pend      <= 1'b0;
            fd_pend       <= 1'b0;
            frame_done    <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end else begin
            frame_done <= acc_in & sof &
                          (fd_pend | (acc_out & m_axis.tlast));
            if (acc_in && sof) begin
                fd_pend <= 1'b0;
            end else if (acc_out && m_axis.tlast) begin
                fd_pend <= 1'b1;
            end
            if (acc_out) begin
                m_axis.tvalid <= 1'b0;
            end
            if (acc_in) begin
                if (sof) begin
                    fc_q <= fc_cfg;
                    fl_q <= fl_cfg;
                end
                line_cnt <= line_nxt;
                pack_cnt <= pack_cnt_nxt;
                if (emit) begin
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata  <= pack_nxt;
                    m_axis.tlast  <= s_axis.tlast;
                    m_axis.tuser  <= sof | sof_pend;
                    pack_buf      <= '0;
                    sof_pend      <= 1'b0;
                end else begin
                    pack_buf      <= pack_nxt;
                    sof_pend      <= sof | sof_pend;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_decimator_nppc.sv
// Directed and random-backpressure bench for video_decimator_nppc (PPC=4, 24-bit pixels).
// Input vectors carry their expected output beats; a monitor scoreboards every output.
module tb_video_decimator_nppc;
    localparam int SPC = 4;
    localparam int PW  = 24;
    localparam int AW  = SPC * PW;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [1:0]    cfg_col_log2;
    logic [3:0]    cfg_line_factor;
    logic          frame_done;

    video_decimator_nppc_if #(.DATA_W(AW)) s_if ();
    video_decimator_nppc_if #(.DATA_W(AW)) m_if ();

    video_decimator_nppc #(
        .SAMPLES_PER_CLOCK(SPC),
        .PIXEL_WIDTH(PW),
        .LINE_FACTOR_BITS(4),
        .COL_LOG2_BITS(2)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cfg_col_log2(cfg_col_log2),
        .cfg_line_factor(cfg_line_factor),
        .s_axis(s_if),
        .m_axis(m_if),
        .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [AW-1:0] d;
        logic          l;
        logic          u;
        logic [1:0]    col;
        logic [3:0]    lf;
        logic          has;
        logic [AW-1:0] ed;
        logic          el;
        logic          eu;
    } vec_t;

    typedef struct {
        logic [AW-1:0] d;
        logic          l;
        logic          u;
    } out_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fd_cnt   = 0;
    logic rand_rdy = 1'b0;

    task automatic check(input string name, input logic [AW-1:0] act,
                         input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] pk(input int a3, input int a2,
                                         input int a1, input int a0);
        return {PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
    endfunction

    function automatic void add(input logic [AW-1:0] d, input logic l,
                                input logic u, input logic [1:0] col,
                                input logic [3:0] lf, input logic has,
                                input logic [AW-1:0] ed, input logic el,
                                input logic eu);
        vec_t v;
        v.d = d; v.l = l; v.u = u; v.col = col; v.lf = lf;
        v.has = has; v.ed = ed; v.el = el; v.eu = eu;
        tbl.push_back(v);
    endfunction

    function automatic void expect_beat(input logic [AW-1:0] d,
                                        input logic l, input logic u);
        out_t o;
        o.d = d; o.l = l; o.u = u;
        exp_q.push_back(o);
    endfunction

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic          stalled = 1'b0;
    logic [AW-1:0] held_d;
    logic          held_l;
    logic          held_u;

    always @(negedge aclk) begin
        if (frame_done) fd_cnt++;
        if (stalled && m_if.tvalid) begin
            check("stall_data", m_if.tdata, held_d);
            check("stall_last", AW'(m_if.tlast), AW'(held_l));
            check("stall_user", AW'(m_if.tuser), AW'(held_u));
        end
        stalled = 1'b0;
        if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_beat: got %h expected no beat", m_if.tdata);
            end else begin
                out_t o;
                o = exp_q.pop_front();
                check("out_data", m_if.tdata, o.d);
                check("out_last", AW'(m_if.tlast), AW'(o.l));
                check("out_user", AW'(m_if.tuser), AW'(o.u));
            end
        end else if (m_if.tvalid) begin
            stalled = 1'b1;
            held_d  = m_if.tdata;
            held_l  = m_if.tlast;
            held_u  = m_if.tuser;
        end
    end

    task automatic send(input logic [AW-1:0] d, input logic l, input logic u);
        int   cyc;
        logic ok;
        cyc = 0;
        ok  = 1'b0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        while (!ok && cyc < 1000) begin
            @(negedge aclk);
            ok = s_if.tready;
            @(posedge aclk);
            #1;
            cyc++;
        end
        s_if.tvalid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got tready=0 expected acceptance");
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && cyc < 1000) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        if (cyc >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0",
                     exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic run_table();
        foreach (tbl[k]) begin
            cfg_col_log2    = tbl[k].col;
            cfg_line_factor = tbl[k].lf;
            if (tbl[k].has) expect_beat(tbl[k].ed, tbl[k].el, tbl[k].eu);
            send(tbl[k].d, tbl[k].l, tbl[k].u);
        end
        tbl.delete();
        drain();
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge aclk);
        check({tag, "_s_tready"}, AW'(s_if.tready), '0);
        check({tag, "_m_tvalid"}, AW'(m_if.tvalid), '0);
        check({tag, "_m_tdata"}, m_if.tdata, '0);
        check({tag, "_m_tlast"}, AW'(m_if.tlast), '0);
        check({tag, "_m_tuser"}, AW'(m_if.tuser), '0);
        check({tag, "_frame_done"}, AW'(frame_done), '0);
    endtask

    logic [AW-1:0] e2 [4];
    logic [PW-1:0] px [8][20];

    initial begin
        aresetn         = 1'b0;
        cfg_col_log2    = 2'd0;
        cfg_line_factor = 4'd1;
        s_if.tvalid     = 1'b0;
        s_if.tdata      = '0;
        s_if.tlast      = 1'b0;
        s_if.tuser      = 1'b0;
        repeat (3) @(posedge aclk);
        check_reset_state("reset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Fc=1, Fl=1 pass-through, 2 lines x 2 beats
        for (int b = 0; b < 4; b++) begin
            add(pk(4*b+3, 4*b+2, 4*b+1, 4*b), b[0], b == 0, 2'd0, 4'd1,
                1'b1, pk(4*b+3, 4*b+2, 4*b+1, 4*b), b[0], b == 0);
        end
        run_table();

        // Fc=2, Fl=2, 4 lines x 4 beats, pixel = 16*line + col
        e2[0] = pk(6, 4, 2, 0);
        e2[1] = pk(14, 12, 10, 8);
        e2[2] = pk(38, 36, 34, 32);
        e2[3] = pk(46, 44, 42, 40);
        for (int ln = 0; ln < 4; ln++) begin
            for (int b = 0; b < 4; b++) begin
                int p;
                p = 16*ln + 4*b;
                add(pk(p+3, p+2, p+1, p), b == 3, ln == 0 && b == 0, 2'd1,
                    4'd2, (ln % 2 == 0) && (b % 2 == 1), e2[(ln/2)*2 + b/2],
                    b == 3, ln == 0 && b == 1);
            end
        end
        fd_cnt = 0;
        run_table();
        check("frame_done_pulses", AW'(fd_cnt), AW'(1));

        // Fc=4, 6-beat line: one full beat then a zero-padded partial flush
        for (int b = 0; b < 6; b++) begin
            add(pk(4*b+3, 4*b+2, 4*b+1, 4*b), b == 5, b == 0, 2'd2, 4'd1,
                b == 3 || b == 5,
                (b == 3) ? pk(12, 8, 4, 0) : pk(0, 0, 20, 16), b == 5, b == 3);
        end
        run_table();

        // Column factor clamps to the beat width; line factor 0 behaves as 1
        add(pk(3, 2, 1, 0), 1'b0, 1'b1, 2'd3, 4'd0, 1'b0, '0, 1'b0, 1'b0);
        add(pk(7, 6, 5, 4), 1'b1, 1'b0, 2'd3, 4'd0, 1'b1, pk(0, 0, 4, 0),
            1'b1, 1'b1);
        add(pk(11, 10, 9, 8), 1'b1, 1'b0, 2'd3, 4'd0, 1'b1, pk(0, 0, 0, 8),
            1'b1, 1'b0);
        run_table();

        // Config change mid-frame only takes effect at the next SOF
        add(pk(3, 2, 1, 0), 1'b0, 1'b1, 2'd0, 4'd1, 1'b1, pk(3, 2, 1, 0),
            1'b0, 1'b1);
        add(pk(7, 6, 5, 4), 1'b1, 1'b0, 2'd1, 4'd1, 1'b1, pk(7, 6, 5, 4),
            1'b1, 1'b0);
        add(pk(103, 102, 101, 100), 1'b0, 1'b1, 2'd1, 4'd1, 1'b0, '0,
            1'b0, 1'b0);
        add(pk(107, 106, 105, 104), 1'b1, 1'b0, 2'd1, 4'd1, 1'b1,
            pk(106, 104, 102, 100), 1'b1, 1'b1);
        run_table();

        // Random backpressure, Fc=2, Fl=3, 8 lines x 5 beats
        for (int ln = 0; ln < 8; ln++) begin
            for (int c = 0; c < 20; c++) px[ln][c] = PW'($urandom);
        end
        for (int ln = 0; ln < 8; ln += 3) begin
            for (int ob = 0; ob < 3; ob++) begin
                logic [AW-1:0] d;
                d = '0;
                for (int k = 0; k < 4; k++) begin
                    int kp;
                    kp = ob*4 + k;
                    if (kp < 10) d[k*PW +: PW] = px[ln][2*kp];
                end
                expect_beat(d, ob == 2, ln == 0 && ob == 0);
            end
        end
        rand_rdy        = 1'b1;
        cfg_col_log2    = 2'd1;
        cfg_line_factor = 4'd3;
        for (int ln = 0; ln < 8; ln++) begin
            for (int b = 0; b < 5; b++) begin
                send({px[ln][4*b+3], px[ln][4*b+2], px[ln][4*b+1], px[ln][4*b]},
                     b == 4, ln == 0 && b == 0);
            end
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge aclk);
        #1;

        // Reset in the middle of a partially packed line
        cfg_col_log2    = 2'd2;
        cfg_line_factor = 4'd1;
        send(pk(3, 2, 1, 4), 1'b0, 1'b1);
        send(pk(7, 6, 5, 5), 1'b0, 1'b0);
        send(pk(11, 10, 9, 6), 1'b0, 1'b0);
        aresetn = 1'b0;
        @(posedge aclk);
        check_reset_state("midreset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        add(pk(13, 12, 11, 10), 1'b0, 1'b1, 2'd2, 4'd1, 1'b0, '0, 1'b0, 1'b0);
        add(pk(23, 22, 21, 20), 1'b1, 1'b0, 2'd2, 4'd1, 1'b1,
            pk(0, 0, 20, 10), 1'b1, 1'b1);
        run_table();

        check("queue_empty", AW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
